fp_stream_minmax: RTL
=====================

Name: fp_stream_minmax

Overview:
- Sequential stage directly downstream of the IEEE-754 single-precision comparator.
- Consumes a valid/ready stream of 32-bit floats grouped into frames by `in_last`.
- Per frame, tracks the running maximum and minimum and their sample indices, counts samples and NaNs, then presents one result record on a valid/ready output.
- Feeds statistics/peak-detect logic downstream.

Parameters:
- WIDTH, 32, float word width; only 32 (binary32) is supported.
- CNT_W, 16, width of the sample counter, the NaN counter and the index fields.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  WIDTH  IEEE-754 sample.
- in_last  in  1  sample is the last of its frame.
- out_valid  out  1  result record valid.
- out_ready  in  1  downstream accepts the record.
- out_max  out  WIDTH  largest non-NaN sample of the frame.
- out_min  out  WIDTH  smallest non-NaN sample of the frame.
- out_max_idx  out  CNT_W  index of out_max within the frame.
- out_min_idx  out  CNT_W  index of out_min within the frame.
- out_count  out  CNT_W  samples in the frame, NaNs included.
- out_nan_count  out  CNT_W  NaN samples in the frame.
- out_all_nan  out  1  frame contained no non-NaN sample.
- out_overflow  out  1  frame length exceeded 2^CNT_W-1.

Behaviour:
- Reset: one clock, `clk`; reset is asynchronous and active-high on `rst`.
  - While `rst` is high: state=IDLE, all outputs 0, `in_ready`=0.
  - After `rst` deasserts: `in_ready`=1.
- A transfer occurs on a rising clk edge with valid&ready high on the same side.
- State IDLE (no sample yet in the frame):
  - On accept, load max=min=sample, both idx=0, count=1, nan_count=isnan.
  - Next state: ACCUM, or EMIT if `in_last` is set.
- State ACCUM:
  - Accepts one sample per cycle, no bubbles.
  - Index of the new sample = current count.
  - count and nan_count increment.
  - On `in_last` accept, go to EMIT.
- State EMIT:
  - `in_ready`=0 and `out_valid`=1.
  - Outputs come from registers and are stable until accepted.
  - On `out_ready`, go to IDLE next cycle. No same-cycle input accept, so there is one bubble per frame.
- Latency: the record is visible the cycle after the `in_last` transfer.
- NaN definition: exponent=8'hFF and fraction!=0.
  - NaNs never update max/min; they only increment count and nan_count.
  - If max/min hold no valid value yet (all samples so far NaN), the first non-NaN sample loads both max and min with its index.
- All-NaN frame: `out_all_nan`=1, `out_max`=`out_min`=32'h7FC00000, both idx=0.
- Ordering rules:
  - Sign first, then exponent, then fraction; magnitude order is reversed for negatives.
  - -0.0 < +0.0.
  - ±inf are ordinary values.
- Update rules:
  - max updates only on strictly greater; min updates only on strictly less.
  - Ties keep the earliest index.
  - A single sample may update both max and min (first valid sample only).
- Counter saturation:
  - count saturates at 2^CNT_W-1 and sets the overflow flag for the frame.
  - Indices beyond saturation report the saturated value.
  - nan_count saturates likewise.
- Reset mid-frame or mid-EMIT discards the partial frame or pending record. The next frame starts at index 0.
- `in_data` and `in_last` are ignored when no transfer occurs.

Decomposition:
- Package `fp_pkg`:
  - Constants: WIDTH=32, EXP_W=8, FRAC_W=23, EXP_ALL_ONES=8'hFF, CANON_NAN=32'h7FC00000.
  - Function `is_nan`.
  - State enum {IDLE, ACCUM, EMIT}.
- Sub-module `fp_order_cmp`: combinational, inputs a and b (non-NaN), outputs gt/lt/eq using the ordering above.
- Two instances are used: sample vs max, and sample vs min.

Test Plan:
- Ordinary frame: [3F800000, C0000000, 40600000 last] -> max=40600000 idx2, min=C0000000 idx1, count=3, nan_count=0, all_nan=0.
- NaNs mixed with one value: [7FC00001, 3F800000, 7F800001 last] -> max=min=3F800000, both idx1, count=3, nan_count=2.
- All-NaN frame: [FFC00000 last] -> all_nan=1, max=min=7FC00000, count=1, nan_count=1.
- Signed zeros and infinity: [00000000, 80000000, 7F800000, 3F800000 last] -> min=80000000 idx1, max=7F800000 idx2.
- Ties: [3F800000, 3F800000 last] -> both idx=0.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles -> record stable and `in_ready`=0 throughout.
  - Pulse `out_ready` -> `out_valid` drops next cycle.
  - Next frame is accepted from the cycle after that.
- Reset mid-frame: assert `rst` after 2 samples of a frame -> outputs 0 immediately. A new frame [40000000 last] then reports count=1, idx=0.

Source files
------------

// File: rtl/fp_stream_minmax_pkg.sv
// Shared binary32 constants, NaN test and frame-tracker state encoding for
// the float stream min/max stage.
package fp_pkg;

  localparam int          WIDTH        = 32;
  localparam int          EXP_W        = 8;
  localparam int          FRAC_W       = 23;
  localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;
  localparam logic [31:0] CANON_NAN    = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  function automatic logic is_nan(input logic [WIDTH-1:0] x);
    return (x[WIDTH-2 -: EXP_W] == EXP_ALL_ONES) && (x[FRAC_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/fp_stream_minmax_if.sv
// Sample-in / record-out stream bundle. Handshake: a beat transfers on the
// rising clk edge where valid and ready are both high; the sender holds its
// payload and valid steady until that edge.
interface fp_stream_minmax_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic [WIDTH-1:0] out_min;
  logic [CNT_W-1:0] out_max_idx;
  logic [CNT_W-1:0] out_min_idx;
  logic [CNT_W-1:0] out_count;
  logic [CNT_W-1:0] out_nan_count;
  logic             out_all_nan;
  logic             out_overflow;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_max, out_min, out_max_idx, out_min_idx,
           out_count, out_nan_count, out_all_nan, out_overflow
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_max, out_min, out_max_idx, out_min_idx,
           out_count, out_nan_count, out_all_nan, out_overflow
  );
endinterface

// File: rtl/fp_stream_minmax_order_cmp.sv
// Total order on non-NaN binary32 values: sign first, then magnitude
// (reversed for negatives), so -0.0 < +0.0 and infinities sort at the ends.
module fp_order_cmp (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        gt,
  output logic        lt,
  output logic        eq
);
  logic mag_gt;
  logic mag_lt;

  assign mag_gt = a[30:0] > b[30:0];
  assign mag_lt = a[30:0] < b[30:0];

  always_comb begin
    eq = (a == b);
    gt = 1'b0;
    lt = 1'b0;
    if (a[31] != b[31]) begin
      gt = ~a[31];
      lt =  a[31];
    end else if (a[31]) begin
      gt = mag_lt;
      lt = mag_gt;
    end else begin
      gt = mag_gt;
      lt = mag_lt;
    end
  end
endmodule

// File: rtl/fp_stream_minmax.sv
// Per-frame running max/min (with indices), sample and NaN counts for a
// binary32 stream; one result record is held per frame until accepted.
module fp_stream_minmax #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  fp_stream_minmax_if.slave bus,
  output fp_pkg::state_t  dbg_state
);
  import fp_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic             in_ready_q;
  logic [WIDTH-1:0] max_q, min_q;
  logic [CNT_W-1:0] max_idx_q, min_idx_q, count_q, nan_cnt_q;
  logic             have_q, all_nan_q, ovf_q;
  logic             accept, out_fire, smp_nan, gt_max, lt_min;
  logic             unused_eq_max, unused_eq_min;
  logic             have_d;

  assign accept   = bus.in_valid & in_ready_q;
  assign out_fire = (state_q == EMIT) & bus.out_ready;
  assign smp_nan  = is_nan(bus.in_data);

  fp_order_cmp u_cmp_max (.a(bus.in_data), .b(max_q), .gt(gt_max), .lt(), .eq(unused_eq_max));
  fp_order_cmp u_cmp_min (.a(bus.in_data), .b(min_q), .gt(), .lt(lt_min), .eq(unused_eq_min));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = bus.in_last ? EMIT : ACCUM;
      ACCUM:   if (accept && bus.in_last) state_d = EMIT;
      EMIT:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Whether a non-NaN value will be held after this beat.
  assign have_d = (state_q == IDLE) ? ~smp_nan : (have_q | ~smp_nan);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != EMIT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
      count_q   <= '0;
      nan_cnt_q <= '0;
      have_q    <= 1'b0;
      all_nan_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (accept) begin
        have_q <= have_d;
        if (bus.in_last) all_nan_q <= ~have_d;
        if (state_q == IDLE) begin
          count_q   <= {{(CNT_W-1){1'b0}}, 1'b1};
          nan_cnt_q <= {{(CNT_W-1){1'b0}}, smp_nan};
          max_idx_q <= '0;
          min_idx_q <= '0;
          ovf_q     <= 1'b0;
          max_q     <= smp_nan ? CANON_NAN : bus.in_data;
          min_q     <= smp_nan ? CANON_NAN : bus.in_data;
        end else begin
          // The new sample's index is the pre-increment (saturated) count.
          if (count_q != CNT_MAX) count_q <= count_q + 1'b1;
          else                    ovf_q   <= 1'b1;
          if (smp_nan && nan_cnt_q != CNT_MAX) nan_cnt_q <= nan_cnt_q + 1'b1;
          if (!smp_nan) begin
            if (!have_q || gt_max) begin
              max_q     <= bus.in_data;
              max_idx_q <= count_q;
            end
            if (!have_q || lt_min) begin
              min_q     <= bus.in_data;
              min_idx_q <= count_q;
            end
          end
        end
      end
      if (out_fire) all_nan_q <= 1'b0;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = (state_q == EMIT);
  assign bus.out_max       = max_q;
  assign bus.out_min       = min_q;
  assign bus.out_max_idx   = max_idx_q;
  assign bus.out_min_idx   = min_idx_q;
  assign bus.out_count     = count_q;
  assign bus.out_nan_count = nan_cnt_q;
  assign bus.out_all_nan   = all_nan_q;
  assign bus.out_overflow  = ovf_q;
  assign dbg_state         = state_q;
endmodule
